// File: rtl/tiny_instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// tiny_instr_sequencer_if
//   Bus between a controller (loads programs, starts/stops runs) and the
//   tiny_instr_sequencer. Clock and reset stay outside the interface.
//
//   Controller -> sequencer : Load_en, Load_addr, Load_data, Start, Stop
//   Sequencer  -> controller: Instr, Instr_valid, Pc, Busy, Done
//
//   modport master : the controller side
//   modport slave  : the sequencer side
// -----------------------------------------------------------------------------
interface tiny_instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              Load_en;
  logic [ADDR_W-1:0] Load_addr;
  logic [11:0]       Load_data;
  logic              Start;
  logic              Stop;
  logic [11:0]       Instr;
  logic              Instr_valid;
  logic [ADDR_W-1:0] Pc;
  logic              Busy;
  logic              Done;

  modport master (
    output Load_en, Load_addr, Load_data, Start, Stop,
    input  Instr, Instr_valid, Pc, Busy, Done
  );

  modport slave (
    input  Load_en, Load_addr, Load_data, Start, Stop,
    output Instr, Instr_valid, Pc, Busy, Done
  );
endinterface

// File: rtl/tiny_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tiny_instr_sequencer
//   Program sequencer placed in front of the TinyCPU. It holds a small
//   loadable program memory of 12-bit words. On Start it plays the program
//   from address 0. Each word stays on Instr for HOLD_CYCLES clocks. The run
//   ends at a HALT word or at the last address, and Done is then raised.
//
//   Ports
//     Clk   : rising-edge clock
//     Rst_n : asynchronous active-low reset
//     bus   : tiny_instr_sequencer_if.slave
//             Load_en/Load_addr/Load_data : program write (IDLE/DONE only)
//             Start : run from address 0 (IDLE/DONE only)
//             Stop  : abort, return to IDLE (priority over everything)
//             Instr : registered instruction to the CPU, IDLE_WORD when idle
//             Instr_valid, Pc, Busy, Done : registered status
// -----------------------------------------------------------------------------
module tiny_instr_sequencer #(
  parameter int          ADDR_W      = 4,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [3:0]  HALT_OP     = 4'b1111,
  parameter logic [11:0] IDLE_WORD   = 12'hF00
) (
  input logic                  Clk,
  input logic                  Rst_n,
  tiny_instr_sequencer_if.slave bus
);

  localparam int               DEPTH       = 2 ** ADDR_W;
  localparam logic [7:0]       HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered state and outputs
  state_t            r_state;
  logic [11:0]       r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_cnt;
  logic              r_busy;
  logic              r_done;

  logic [11:0]       r_mem [DEPTH];

  // Next-state values
  state_t            w_state;
  logic [11:0]       w_instr;
  logic              w_valid;
  logic [ADDR_W-1:0] w_pc;
  logic [7:0]        w_cnt;
  logic              w_busy;
  logic              w_done;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_next_pc;
  logic [11:0]       w_first_word;
  logic [11:0]       w_next_word;

  // Writes are accepted only when no program is executing.
  assign w_mem_we     = bus.Load_en && (r_state != S_RUN);
  assign w_next_pc    = r_pc + 1'b1;
  assign w_first_word = r_mem[0];
  assign w_next_word  = r_mem[w_next_pc];

  // NOTE: the program memory has no reset. Its contents must survive Rst_n,
  // and leaving the reset out lets the array map onto plain RAM.
  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      r_mem[bus.Load_addr] <= bus.Load_data;
    end
  end

  // NOTE: every signal gets a default at the top of this block. Then no path
  // leaves a value unassigned, so no latch can be inferred.
  always_comb begin
    w_state = r_state;
    w_instr = r_instr;
    w_valid = r_valid;
    w_pc    = r_pc;
    w_cnt   = r_cnt;
    w_busy  = r_busy;
    w_done  = r_done;

    if (bus.Stop) begin
      // Abort from any state. In IDLE these values are already present.
      w_state = S_IDLE;
      w_instr = IDLE_WORD;
      w_valid = 1'b0;
      w_pc    = '0;
      w_cnt   = '0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          // A write in the same cycle wins, and Start is dropped.
          if (bus.Start && !bus.Load_en) begin
            w_pc  = '0;
            w_cnt = HOLD_RELOAD;
            if (w_first_word[11:8] == HALT_OP) begin
              // An empty program completes at once. The HALT word is never forwarded.
              w_state = S_DONE;
              w_instr = IDLE_WORD;
              w_valid = 1'b0;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_state = S_RUN;
              w_instr = w_first_word;
              w_valid = 1'b1;
              w_busy  = 1'b1;
              w_done  = 1'b0;
            end
          end
        end

        S_RUN: begin
          if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end else if ((r_pc == LAST_ADDR) || (w_next_word[11:8] == HALT_OP)) begin
            // The run ends. Pc keeps the last executed address. The program
            // never wraps back to address 0.
            w_state = S_DONE;
            w_instr = IDLE_WORD;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_pc    = w_next_pc;
            w_instr = w_next_word;
            w_cnt   = HOLD_RELOAD;
          end
        end

        default: begin
          w_state = S_IDLE;
          w_instr = IDLE_WORD;
          w_valid = 1'b0;
          w_pc    = '0;
          w_cnt   = '0;
          w_busy  = 1'b0;
          w_done  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments. Every register then
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_instr <= IDLE_WORD;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_instr <= w_instr;
      r_valid <= w_valid;
      r_pc    <= w_pc;
      r_cnt   <= w_cnt;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.Instr       = r_instr;
  assign bus.Instr_valid = r_valid;
  assign bus.Pc          = r_pc;
  assign bus.Busy        = r_busy;
  assign bus.Done        = r_done;

endmodule

// File: tb/tb_tiny_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tiny_instr_sequencer
//   Directed bench for tiny_instr_sequencer (ADDR_W=4, HOLD_CYCLES=4).
//   A shadow array prog[] holds the contents the memory should have. Inputs
//   are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_tiny_instr_sequencer;

  localparam int          ADDR_W = 4;
  localparam int          HOLD   = 4;
  localparam logic [11:0] IDLE_W = 12'hF00;

  logic Clk;
  logic Rst_n;

  tiny_instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  tiny_instr_sequencer #(
    .ADDR_W      (ADDR_W),
    .HOLD_CYCLES (HOLD),
    .HALT_OP     (4'b1111),
    .IDLE_WORD   (IDLE_W)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [11:0] prog [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] addr, input logic [11:0] data);
    bus.Load_en   = 1'b1;
    bus.Load_addr = addr;
    bus.Load_data = data;
    step();
    bus.Load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.Stop = 1'b1;
    step();
    bus.Stop = 1'b0;
  endtask

  // Bounded wait for Done. An expired bound counts as a failed comparison.
  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.Done && n < budget) begin
      step();
      n++;
    end
    check("wait_done", {31'd0, bus.Done}, 32'd1);
  endtask

  // Start, then follow k words of prog[] cycle by cycle, then expect DONE.
  task automatic expect_run(input string tag, input int k);
    pulse_start();
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < HOLD; j++) begin
        check({tag, "_instr"}, {20'd0, bus.Instr}, {20'd0, prog[i]});
        if (j == 0) begin
          check({tag, "_pc"}, {28'd0, bus.Pc}, i);
          check({tag, "_valid"}, {31'd0, bus.Instr_valid}, 32'd1);
        end
        step();
      end
    end
    check({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
    check({tag, "_end_instr"}, {20'd0, bus.Instr}, {20'd0, IDLE_W});
    check({tag, "_end_valid"}, {31'd0, bus.Instr_valid}, 32'd0);
    check({tag, "_end_busy"}, {31'd0, bus.Busy}, 32'd0);
    check({tag, "_end_pc"}, {28'd0, bus.Pc}, k - 1);
  endtask

  task automatic load_basic();
    logic [11:0] words [9];
    words = '{12'h000, 12'h107, 12'h208, 12'h400, 12'h900,
              12'hB00, 12'h600, 12'h300, 12'hF00};
    for (int i = 0; i < 9; i++) begin
      load(4'(i), words[i]);
      prog[i] = words[i];
    end
  endtask

  initial begin
    int n;
    bus.Load_en = 1'b0; bus.Load_addr = '0; bus.Load_data = '0;
    bus.Start = 1'b0; bus.Stop = 1'b0;
    Rst_n = 1'b0;
    step(2);

    // Reset state
    check("rst_instr", {20'd0, bus.Instr}, {20'd0, IDLE_W});
    check("rst_valid", {31'd0, bus.Instr_valid}, 32'd0);
    check("rst_pc",    {28'd0, bus.Pc}, 32'd0);
    check("rst_busy",  {31'd0, bus.Busy}, 32'd0);
    check("rst_done",  {31'd0, bus.Done}, 32'd0);
    #3 Rst_n = 1'b1;
    step();

    // Basic program: 8 words then HALT at address 8
    load_basic();
    expect_run("basic", 8);

    // End of memory: 16 x 400, no HALT, no wrap
    for (int i = 0; i < 16; i++) begin
      load(4'(i), 12'h400);
      prog[i] = 12'h400;
    end
    pulse_start();
    n = 0;
    while (bus.Instr_valid && n < 100) begin
      step();
      n++;
    end
    check("eom_cycles", n, 32'd64);
    check("eom_done",   {31'd0, bus.Done}, 32'd1);
    check("eom_pc",     {28'd0, bus.Pc}, 32'd15);
    check("eom_instr",  {20'd0, bus.Instr}, {20'd0, IDLE_W});

    // Immediate halt: F05 never reaches Instr
    load(4'd0, 12'hF05);
    prog[0] = 12'hF05;
    pulse_start();
    check("ihalt_done",  {31'd0, bus.Done}, 32'd1);
    check("ihalt_valid", {31'd0, bus.Instr_valid}, 32'd0);
    check("ihalt_instr", {20'd0, bus.Instr}, {20'd0, IDLE_W});
    check("ihalt_busy",  {31'd0, bus.Busy}, 32'd0);

    // Stop mid-run at Pc=3, counter=2
    load_basic();
    pulse_start();
    step(3 * HOLD + 1);
    check("stop_pre_pc", {28'd0, bus.Pc}, 32'd3);
    pulse_stop();
    check("stop_pc",    {28'd0, bus.Pc}, 32'd0);
    check("stop_instr", {20'd0, bus.Instr}, {20'd0, IDLE_W});
    check("stop_valid", {31'd0, bus.Instr_valid}, 32'd0);
    check("stop_done",  {31'd0, bus.Done}, 32'd0);
    check("stop_busy",  {31'd0, bus.Busy}, 32'd0);
    step(3);
    check("stop_hold_instr", {20'd0, bus.Instr}, {20'd0, IDLE_W});
    expect_run("replay", 8);

    // Write protection: Load_en during RUN is ignored
    pulse_start();
    step(2);
    check("wp_busy", {31'd0, bus.Busy}, 32'd1);
    load(4'd2, 12'h000);
    wait_done(100);
    expect_run("wp_rerun", 8);

    // Load and Start in the same cycle: write lands, FSM stays put
    pulse_stop();
    bus.Load_en   = 1'b1;
    bus.Load_addr = 4'd0;
    bus.Load_data = 12'h123;
    bus.Start     = 1'b1;
    step();
    bus.Load_en = 1'b0;
    bus.Start   = 1'b0;
    prog[0] = 12'h123;
    check("ls_busy",  {31'd0, bus.Busy}, 32'd0);
    check("ls_valid", {31'd0, bus.Instr_valid}, 32'd0);
    check("ls_done",  {31'd0, bus.Done}, 32'd0);
    expect_run("ls_run", 8);

    // Async reset mid-cycle during RUN
    pulse_start();
    step(5);
    check("ar_pre_busy", {31'd0, bus.Busy}, 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("ar_instr", {20'd0, bus.Instr}, {20'd0, IDLE_W});
    check("ar_valid", {31'd0, bus.Instr_valid}, 32'd0);
    check("ar_pc",    {28'd0, bus.Pc}, 32'd0);
    check("ar_busy",  {31'd0, bus.Busy}, 32'd0);
    check("ar_done",  {31'd0, bus.Done}, 32'd0);
    #3 Rst_n = 1'b1;
    step();
    expect_run("ar_rerun", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish before 200000 ns");
    $fatal(1);
  end

endmodule
